// File: rtl/regfile_bypass_sb.sv
// Multi-port register file with a per-register pending scoreboard.
//
// Byte-lane writes from NWP ports. When several ports hit the same lane in
// one cycle, the highest-numbered port wins. Reads are combinational on
// NRP ports. With BYPASS=1 they see the lanes being written this cycle.
// A single set port marks a register pending (busy). Any write port with
// wr_clr clears that register's busy bit. A set beats a clear to the same
// register in the same cycle.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en/wr_reg/wr_strb/wr_data/wr_clr
//                        per-write-port enable, index, byte strobes, data,
//                        and scoreboard clear (flattened, port p in slice p)
//   rd_reg               per-read-port index (flattened)
//   rd_data, rd_busy     per-read-port data and busy bit (combinational)
//   sb_set_en/sb_set_reg set request and target index
//   sb_set_rdy           set can be accepted (combinational)
//   busy                 registered scoreboard bits
//   regs_flat            registered contents, register r at [r*DW +: DW]
module regfile_bypass_sb #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NREG   = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned NWP    = 3,
  parameter int unsigned NRP    = 4,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWP-1:0]        wr_en,
  input  logic [NWP*AW-1:0]     wr_reg,
  input  logic [NWP*DW/8-1:0]   wr_strb,
  input  logic [NWP*DW-1:0]     wr_data,
  input  logic [NWP-1:0]        wr_clr,
  input  logic [NRP*AW-1:0]     rd_reg,
  output logic [NRP*DW-1:0]     rd_data,
  output logic [NRP-1:0]        rd_busy,
  input  logic                  sb_set_en,
  input  logic [AW-1:0]         sb_set_reg,
  output logic                  sb_set_rdy,
  output logic [NREG-1:0]       busy,
  output logic [NREG*DW-1:0]    regs_flat
);

  localparam int unsigned NB = DW / 8;

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            set_acc;

  // Merge all port writes into the next-state image. Ascending port order
  // lets a higher port overwrite a lower one lane by lane. Lanes the winner
  // leaves alone keep the lower port's data.
  always_comb begin : write_merge
    for (int unsigned r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int unsigned p = 0; p < NWP; p++) begin
      if (wr_en[p]) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (wr_strb[p*NB + b]) begin
            regs_d[wr_reg[p*AW +: AW]][b*8 +: 8] = wr_data[p*DW + b*8 +: 8];
          end
        end
      end
    end
  end

  assign sb_set_rdy = ~busy_q[sb_set_reg];
  assign set_acc    = sb_set_en & ~busy_q[sb_set_reg];

  // Clears are applied first and the accepted set last, so the set wins.
  always_comb begin : busy_next
    busy_d = busy_q;
    for (int unsigned p = 0; p < NWP; p++) begin
      if (wr_en[p] && wr_clr[p]) begin
        busy_d[wr_reg[p*AW +: AW]] = 1'b0;
      end
    end
    if (set_acc) begin
      busy_d[sb_set_reg] = 1'b1;
    end
  end

  // regs_d already holds the winning lane data, so bypass just reads it.
  always_comb begin : read_ports
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned q = 0; q < NRP; q++) begin
      if (BYPASS != 0) begin
        rd_data[q*DW +: DW] = regs_d[rd_reg[q*AW +: AW]];
      end else begin
        rd_data[q*DW +: DW] = regs_q[rd_reg[q*AW +: AW]];
      end
      rd_busy[q] = busy_q[rd_reg[q*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  for (genvar r = 0; r < NREG; r++) begin : g_flat
    assign regs_flat[r*DW +: DW] = regs_q[r];
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
module tb_regfile_bypass_sb;

  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned NWP  = 3;
  localparam int unsigned NRP  = 4;
  localparam int unsigned NB   = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_reg;
  logic [NWP*NB-1:0]   wr_strb;
  logic [NWP*DW-1:0]   wr_data;
  logic [NWP-1:0]      wr_clr;
  logic [NRP*AW-1:0]   rd_reg;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_reg;

  logic [NRP*DW-1:0]   rd_data,   rd_data_nb;
  logic [NRP-1:0]      rd_busy,   rd_busy_nb;
  logic                sb_set_rdy, sb_set_rdy_nb;
  logic [NREG-1:0]     busy,      busy_nb;
  logic [NREG*DW-1:0]  regs_flat, regs_flat_nb;

  regfile_bypass_sb #(.DW(DW), .NREG(NREG), .AW(AW), .NWP(NWP), .NRP(NRP), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_strb(wr_strb),
    .wr_data(wr_data), .wr_clr(wr_clr), .rd_reg(rd_reg), .rd_data(rd_data),
    .rd_busy(rd_busy), .sb_set_en(sb_set_en), .sb_set_reg(sb_set_reg),
    .sb_set_rdy(sb_set_rdy), .busy(busy), .regs_flat(regs_flat)
  );

  regfile_bypass_sb #(.DW(DW), .NREG(NREG), .AW(AW), .NWP(NWP), .NRP(NRP), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_strb(wr_strb),
    .wr_data(wr_data), .wr_clr(wr_clr), .rd_reg(rd_reg), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .sb_set_en(sb_set_en), .sb_set_reg(sb_set_reg),
    .sb_set_rdy(sb_set_rdy_nb), .busy(busy_nb), .regs_flat(regs_flat_nb)
  );

  typedef struct {
    logic [NWP-1:0]    en;
    logic [NWP-1:0]    clr;
    logic [NWP*AW-1:0] wreg;
    logic [NWP*NB-1:0] strb;
    logic [NWP*DW-1:0] data;
    logic              set_en;
    logic [AW-1:0]     set_reg;
    logic [AW-1:0]     rreg;
    logic [DW-1:0]     exp_rd_b;
    logic [DW-1:0]     exp_rd_nb;
    logic              exp_rdy;
    logic              exp_rbusy;
    logic [AW-1:0]     chk_reg;
    logic [DW-1:0]     exp_chk;
    logic [NREG-1:0]   exp_busy;
  } vec_t;

  typedef struct {
    int              idx;
    logic [AW-1:0]   reg_idx;
    logic [DW-1:0]   val;
    logic [NREG-1:0] busy;
  } sb_t;

  vec_t vecs[$];
  vec_t cur;
  sb_t  sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr(input int p, input logic e, input logic [2:0] r, input logic [3:0] s,
                    input logic [31:0] d, input logic c);
    cur.en[p]              = e;
    cur.wreg[p*AW +: AW]   = r;
    cur.strb[p*NB +: NB]   = s;
    cur.data[p*DW +: DW]   = d;
    cur.clr[p]             = c;
  endtask

  task automatic add(input logic [2:0] rr, input logic se, input logic [2:0] sr,
                     input logic [31:0] eb, input logic [31:0] enb, input logic erdy,
                     input logic erb, input logic [2:0] cr, input logic [31:0] ec,
                     input logic [7:0] ebusy);
    cur.rreg = rr; cur.set_en = se; cur.set_reg = sr;
    cur.exp_rd_b = eb; cur.exp_rd_nb = enb; cur.exp_rdy = erdy; cur.exp_rbusy = erb;
    cur.chk_reg = cr; cur.exp_chk = ec; cur.exp_busy = ebusy;
    vecs.push_back(cur);
    cur = '{default: '0};
  endtask

  task automatic idle();
    wr_en = '0; wr_reg = '0; wr_strb = '0; wr_data = '0; wr_clr = '0;
    rd_reg = '0; sb_set_en = 1'b0; sb_set_reg = '0;
  endtask

  task automatic apply(input vec_t v);
    wr_en = v.en; wr_reg = v.wreg; wr_strb = v.strb; wr_data = v.data; wr_clr = v.clr;
    rd_reg = {NRP{v.rreg}}; sb_set_en = v.set_en; sb_set_reg = v.set_reg;
  endtask

  logic [DW-1:0]      fin [NREG];
  logic [NREG*DW-1:0] fin_flat;

  initial begin
    cur = '{default: '0};
    // Single full write, then a quiet read-back.
    wr(0, 1, 3'd3, 4'hF, 32'hAABBCCDD, 0);
    add(3'd3, 0, 3'd0, 32'hAABBCCDD, 32'h0, 1, 0, 3'd3, 32'hAABBCCDD, 8'h00);
    add(3'd3, 0, 3'd0, 32'hAABBCCDD, 32'hAABBCCDD, 1, 0, 3'd0, 32'h0, 8'h00);
    // Port 2 wins the low half over port 0.
    wr(0, 1, 3'd5, 4'hF, 32'h11111111, 0);
    wr(2, 1, 3'd5, 4'h3, 32'h22222222, 0);
    add(3'd5, 0, 3'd0, 32'h11112222, 32'h0, 1, 0, 3'd5, 32'h11112222, 8'h00);
    // Upper-half bypass over an existing value.
    wr(0, 1, 3'd2, 4'hF, 32'h01234567, 0);
    add(3'd2, 0, 3'd0, 32'h01234567, 32'h0, 1, 0, 3'd2, 32'h01234567, 8'h00);
    wr(1, 1, 3'd2, 4'hC, 32'hDEADBEEF, 0);
    add(3'd2, 0, 3'd0, 32'hDEAD4567, 32'h01234567, 1, 0, 3'd2, 32'hDEAD4567, 8'h00);
    // Set r4, second set held off, zero-strobe write is a data no-op.
    add(3'd4, 1, 3'd4, 32'h0, 32'h0, 1, 0, 3'd4, 32'h0, 8'h10);
    wr(1, 1, 3'd7, 4'h0, 32'hCAFEF00D, 0);
    add(3'd4, 1, 3'd4, 32'h0, 32'h0, 0, 1, 3'd7, 32'h0, 8'h10);
    // Clear r4 with strobes off: busy drops, data untouched.
    wr(0, 1, 3'd4, 4'h0, 32'h12345678, 1);
    add(3'd4, 0, 3'd4, 32'h0, 32'h0, 0, 1, 3'd4, 32'h0, 8'h00);
    // Set and clear r6 together: set wins.
    wr(2, 1, 3'd6, 4'h0, 32'h0, 1);
    add(3'd6, 1, 3'd6, 32'h0, 32'h0, 1, 0, 3'd6, 32'h0, 8'h40);
    // Clear and data with wr_en low do nothing.
    wr(1, 0, 3'd6, 4'hF, 32'hFFFFFFFF, 1);
    add(3'd6, 0, 3'd6, 32'h0, 32'h0, 0, 1, 3'd6, 32'h0, 8'h40);
    // Three ports on r1 with per-lane winners.
    wr(0, 1, 3'd1, 4'hF, 32'hAAAAAAAA, 0);
    wr(1, 1, 3'd1, 4'h1, 32'hBBBBBBBB, 0);
    wr(2, 1, 3'd1, 4'h2, 32'hCCCCCCCC, 0);
    add(3'd1, 0, 3'd0, 32'hAAAACCBB, 32'h0, 1, 0, 3'd1, 32'hAAAACCBB, 8'h40);
    // Two registers in one cycle, sparse strobes.
    wr(0, 1, 3'd0, 4'h5, 32'hFFFFFFFF, 0);
    wr(2, 1, 3'd3, 4'h8, 32'h99000000, 0);
    add(3'd3, 0, 3'd0, 32'h99BBCCDD, 32'hAABBCCDD, 1, 0, 3'd0, 32'h00FF00FF, 8'h40);
    add(3'd3, 0, 3'd0, 32'h99BBCCDD, 32'h99BBCCDD, 1, 0, 3'd3, 32'h99BBCCDD, 8'h40);

    idle();
    rst_n = 1'b0;
    #12;
    check("reset regs", 256'(regs_flat), 256'h0);
    check("reset busy", 256'(busy), 256'h0);
    check("reset set_rdy", 256'(sb_set_rdy), 256'h1);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      sb_t e;
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d rd_byp", i), 256'(rd_data), 256'({NRP{vecs[i].exp_rd_b}}));
      check($sformatf("v%0d rd_nobyp", i), 256'(rd_data_nb), 256'({NRP{vecs[i].exp_rd_nb}}));
      check($sformatf("v%0d set_rdy", i), 256'({sb_set_rdy, sb_set_rdy_nb}), 256'({2{vecs[i].exp_rdy}}));
      check($sformatf("v%0d rd_busy", i), 256'(rd_busy), 256'({NRP{vecs[i].exp_rbusy}}));
      sbq.push_back('{idx: i, reg_idx: vecs[i].chk_reg, val: vecs[i].exp_chk, busy: vecs[i].exp_busy});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check($sformatf("v%0d reg%0d", e.idx, e.reg_idx), 256'(regs_flat[e.reg_idx*DW +: DW]), 256'(e.val));
      check($sformatf("v%0d reg%0d nb", e.idx, e.reg_idx), 256'(regs_flat_nb[e.reg_idx*DW +: DW]), 256'(e.val));
      check($sformatf("v%0d busy", e.idx), 256'(busy), 256'(e.busy));
      check($sformatf("v%0d busy nb", e.idx), 256'(busy_nb), 256'(e.busy));
    end

    // Whole-file image and all read ports independently indexed.
    fin[0] = 32'h00FF00FF; fin[1] = 32'hAAAACCBB; fin[2] = 32'hDEAD4567; fin[3] = 32'h99BBCCDD;
    fin[4] = 32'h0; fin[5] = 32'h11112222; fin[6] = 32'h0; fin[7] = 32'h0;
    for (int r = 0; r < int'(NREG); r++) fin_flat[r*DW +: DW] = fin[r];
    @(negedge clk);
    idle();
    rd_reg = {3'd6, 3'd3, 3'd1, 3'd0};
    #1;
    check("final regs_flat", 256'(regs_flat), 256'(fin_flat));
    check("multi rd_data", 256'(rd_data), 256'({32'h0, 32'h99BBCCDD, 32'hAAAACCBB, 32'h00FF00FF}));
    check("multi rd_busy", 256'(rd_busy), 256'(4'b1000));

    // Load r1=5 and busy[1], then reset between edges with a write in flight.
    @(negedge clk);
    idle();
    wr_en = 3'b001; wr_reg = 9'(3'd1); wr_strb = 12'hF; wr_data = 96'(32'h5);
    sb_set_en = 1'b1; sb_set_reg = 3'd1;
    @(posedge clk);
    #1;
    check("load r1", 256'(regs_flat[1*DW +: DW]), 256'h5);
    check("load busy", 256'(busy), 256'h42);
    @(negedge clk);
    wr_data = 96'(32'h77); sb_set_reg = 3'd2;
    #2 rst_n = 1'b0;
    #1;
    check("async reset regs", 256'(regs_flat), 256'h0);
    check("async reset busy", 256'(busy), 256'h0);
    @(posedge clk);
    #1;
    check("held reset regs", 256'(regs_flat), 256'h0);
    check("held reset busy", 256'(busy), 256'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset regs", 256'(regs_flat), 256'h0);
    check("post reset busy", 256'(busy), 256'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
REGFILE_BYPASS_SB -- requirements
Module: regfile_bypass_sb

Interface
REQ-001 SHALL have parameter DW, default 32, register width in bits, a multiple of 8.
REQ-002 SHALL have parameter NREG, default 8, register count, a power of 2.
REQ-003 SHALL have parameter AW, default 3, register index width, equal to log2(NREG).
REQ-004 SHALL have parameter NWP, default 3, write port count, 1..4.
REQ-005 SHALL have parameter NRP, default 4, read port count, 1..8.
REQ-006 SHALL have parameter BYPASS, default 1: 1 means same-cycle write-to-read forwarding; 0 means none.
REQ-007 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port wr_en  in  NWP  per-port write enable.
REQ-010 SHALL have port wr_reg  in  NWP*AW  per-port destination index; port p uses bits [p*AW +: AW].
REQ-011 SHALL have port wr_strb  in  NWP*DW/8  per-port byte strobes; bit b enables byte lane b.
REQ-012 SHALL have port wr_data  in  NWP*DW  per-port write data.
REQ-013 SHALL have port wr_clr  in  NWP  per-port scoreboard clear, qualified by wr_en.
REQ-014 SHALL have port rd_reg  in  NRP*AW  per-port read index.
REQ-015 SHALL have port rd_data  out  NRP*DW  per-port read data.
REQ-016 SHALL have port rd_busy  out  NRP  busy bit of the register indexed by rd_reg.
REQ-017 SHALL have port sb_set_en  in  1  request to mark sb_set_reg as pending.
REQ-018 SHALL have port sb_set_reg  in  AW  index to mark as pending.
REQ-019 SHALL have port sb_set_rdy  out  1  high when the scoreboard can accept sb_set_en.
REQ-020 SHALL have port busy  out  NREG  per-register scoreboard bits.
REQ-021 SHALL have port regs_flat  out  NREG*DW  all registered values; register r is at [r*DW +: DW].

Function
REQ-022 SHALL write byte lane b of register r at the clock edge when some port p has wr_en[p]=1, wr_reg=r and wr_strb[b]=1.
REQ-023 SHALL resolve multiple writes to the same register byte lane in one cycle by taking the highest-numbered port; lanes not targeted by the winning port remain available to lower ports.
REQ-024 SHALL leave every byte lane not written in a cycle unchanged.
REQ-025 SHALL return rd_data combinationally, as the stored value of rd_reg, with zero-cycle read latency.
REQ-026 SHALL, when BYPASS=1, replace each byte lane of rd_data with that lane's winning write data for the cycle, if the lane is being written this cycle.
REQ-027 SHALL, when BYPASS=0, return the pre-edge stored value even when the register is being written.
REQ-028 SHALL drive sb_set_rdy = !busy[sb_set_reg]; a set request is accepted only when sb_set_en=1 and sb_set_rdy=1.
REQ-029 SHALL set busy[r] at the edge on an accepted set; an unaccepted request has no effect, and the requester holds it.
REQ-030 SHALL clear busy[r] at the edge when some port has wr_en=1, wr_clr=1 and wr_reg=r, regardless of strobes.
REQ-031 SHALL give set priority over clear when an accepted set and a clear target the same register in the same cycle; the register ends busy.
REQ-032 SHALL drive rd_busy[q] = busy[rd_reg of port q], pre-edge, with no bypass.
REQ-033 SHALL treat wr_clr with wr_en=0 as a no-op.
REQ-034 SHALL treat wr_en=1 with all strobes 0 as a data no-op; the clear is still honoured.

Reset
REQ-035 SHALL, on rst_n low, immediately clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-036 SHALL hold state at 0 while rst_n is low and ignore all writes and sets during that time.
REQ-037 SHALL, on an assertion of rst_n mid-operation, discard any in-flight set or write in that cycle.

Verification
REQ-038 Scenario: reset, then port0 writes r3 with 0xAABBCCDD and strb 0xF -> the next cycle, reading r3 returns 0xAABBCCDD; regs_flat shows 0 for all other registers.
REQ-039 Scenario: same cycle, port0 writes r5 with 0x11111111 and strb 0xF, and port2 writes r5 with 0x22222222 and strb 0x3 -> r5 = 0x11112222.
REQ-040 Scenario: with BYPASS=1, read r2 while port1 writes r2 with 0xDEADBEEF and strb 0xC -> rd_data = 0xDEAD followed by the old lower half, in the same cycle; with BYPASS=0, the old value is returned.
REQ-041 Scenario: set r4 -> busy=0x10 and sb_set_rdy=0 for sb_set_reg=4; a second set to r4 is held off; port0 writes r4 with wr_clr=1 -> busy=0x00.
REQ-042 Scenario: in one cycle, set r6 and clear r6 -> busy[6]=1 afterwards.
REQ-043 Scenario: assert rst_n low between clock edges after loading r1=0x5 and busy[1]=1 -> r1=0 and busy=0 before the next clk edge.
